// File: rtl/alu_control_md_if.sv
// EX-stage bus between the pipeline and the ALU control / mul-div block.
interface alu_control_md_if #(
  parameter int unsigned N          = 32,
  parameter int unsigned N_FN_FIELD = 6,
  parameter int unsigned N_ALU_CTRL = 4,
  parameter int unsigned N_ALU_OP   = 2
);
  logic                  valid;
  logic                  flush;
  logic [N_ALU_OP-1:0]   alu_op;
  logic [N_FN_FIELD-1:0] fn_field;
  logic [N-1:0]          rs_val;
  logic [N-1:0]          rt_val;
  logic [N_ALU_CTRL-1:0] alu_ctrl;
  logic [1:0]            result_sel;
  logic                  illegal;
  logic                  stall;
  logic                  md_busy;
  logic [N-1:0]          hi;
  logic [N-1:0]          lo;

  modport master (
    output valid, flush, alu_op, fn_field, rs_val, rt_val,
    input  alu_ctrl, result_sel, illegal, stall, md_busy, hi, lo
  );

  modport slave (
    input  valid, flush, alu_op, fn_field, rs_val, rt_val,
    output alu_ctrl, result_sel, illegal, stall, md_busy, hi, lo
  );
endinterface

// File: rtl/alu_control_md.sv
// ALU control decoder plus radix-2 iterative multiply/divide engine owning HI/LO.
module alu_control_md #(
  parameter int unsigned N          = 32,
  parameter int unsigned N_FN_FIELD = 6,
  parameter int unsigned N_ALU_CTRL = 4,
  parameter int unsigned N_ALU_OP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  alu_control_md_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int unsigned ACC_W = 2 * N;

  localparam logic [N_FN_FIELD-1:0] FN_ADD   = N_FN_FIELD'(6'b100000);
  localparam logic [N_FN_FIELD-1:0] FN_ADDU  = N_FN_FIELD'(6'b100001);
  localparam logic [N_FN_FIELD-1:0] FN_SUB   = N_FN_FIELD'(6'b100010);
  localparam logic [N_FN_FIELD-1:0] FN_SUBU  = N_FN_FIELD'(6'b100011);
  localparam logic [N_FN_FIELD-1:0] FN_AND   = N_FN_FIELD'(6'b100100);
  localparam logic [N_FN_FIELD-1:0] FN_OR    = N_FN_FIELD'(6'b100101);
  localparam logic [N_FN_FIELD-1:0] FN_XOR   = N_FN_FIELD'(6'b100110);
  localparam logic [N_FN_FIELD-1:0] FN_NOR   = N_FN_FIELD'(6'b100111);
  localparam logic [N_FN_FIELD-1:0] FN_SLT   = N_FN_FIELD'(6'b101010);
  localparam logic [N_FN_FIELD-1:0] FN_SLTU  = N_FN_FIELD'(6'b101011);
  localparam logic [N_FN_FIELD-1:0] FN_SLL   = N_FN_FIELD'(6'b000000);
  localparam logic [N_FN_FIELD-1:0] FN_SRL   = N_FN_FIELD'(6'b000010);
  localparam logic [N_FN_FIELD-1:0] FN_SRA   = N_FN_FIELD'(6'b000011);
  localparam logic [N_FN_FIELD-1:0] FN_MFHI  = N_FN_FIELD'(6'b010000);
  localparam logic [N_FN_FIELD-1:0] FN_MTHI  = N_FN_FIELD'(6'b010001);
  localparam logic [N_FN_FIELD-1:0] FN_MFLO  = N_FN_FIELD'(6'b010010);
  localparam logic [N_FN_FIELD-1:0] FN_MTLO  = N_FN_FIELD'(6'b010011);
  localparam logic [N_FN_FIELD-1:0] FN_MULT  = N_FN_FIELD'(6'b011000);
  localparam logic [N_FN_FIELD-1:0] FN_MULTU = N_FN_FIELD'(6'b011001);
  localparam logic [N_FN_FIELD-1:0] FN_DIV   = N_FN_FIELD'(6'b011010);
  localparam logic [N_FN_FIELD-1:0] FN_DIVU  = N_FN_FIELD'(6'b011011);

  localparam logic [N_ALU_CTRL-1:0] C_AND  = N_ALU_CTRL'(4'b0000);
  localparam logic [N_ALU_CTRL-1:0] C_OR   = N_ALU_CTRL'(4'b0001);
  localparam logic [N_ALU_CTRL-1:0] C_ADD  = N_ALU_CTRL'(4'b0010);
  localparam logic [N_ALU_CTRL-1:0] C_XOR  = N_ALU_CTRL'(4'b0011);
  localparam logic [N_ALU_CTRL-1:0] C_SUB  = N_ALU_CTRL'(4'b0110);
  localparam logic [N_ALU_CTRL-1:0] C_SLT  = N_ALU_CTRL'(4'b0111);
  localparam logic [N_ALU_CTRL-1:0] C_SLTU = N_ALU_CTRL'(4'b1000);
  localparam logic [N_ALU_CTRL-1:0] C_SLL  = N_ALU_CTRL'(4'b1001);
  localparam logic [N_ALU_CTRL-1:0] C_SRL  = N_ALU_CTRL'(4'b1010);
  localparam logic [N_ALU_CTRL-1:0] C_SRA  = N_ALU_CTRL'(4'b1011);
  localparam logic [N_ALU_CTRL-1:0] C_NOR  = N_ALU_CTRL'(4'b1100);
  localparam logic [N_ALU_CTRL-1:0] C_BAD  = N_ALU_CTRL'(4'b1111);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [ACC_W-1:0]      acc_q;
  logic [N-1:0]          opb_q;
  logic                  neg_res_q, neg_rem_q;
  logic [N-1:0]          hi_q, lo_q;

  logic [N_ALU_CTRL-1:0] ctrl_c;
  logic [1:0]            sel_c;
  logic                  illegal_c, md_class_c, is_mul_c, is_div_c, is_signed_c;
  logic                  is_mthi_c, is_mtlo_c;
  logic                  busy_c, step_c, done_c, issue_c, mt_ok_c;

  // Funct decode; md-class flags feed the stall and the engine issue logic.
  always_comb begin
    ctrl_c      = C_BAD;
    sel_c       = 2'b00;
    illegal_c   = 1'b0;
    md_class_c  = 1'b0;
    is_mul_c    = 1'b0;
    is_div_c    = 1'b0;
    is_signed_c = 1'b0;
    is_mthi_c   = 1'b0;
    is_mtlo_c   = 1'b0;
    if (!bus.alu_op[1]) begin
      ctrl_c = bus.alu_op[0] ? C_SUB : C_ADD;
    end else begin
      case (bus.fn_field)
        FN_ADD, FN_ADDU: ctrl_c = C_ADD;
        FN_SUB, FN_SUBU: ctrl_c = C_SUB;
        FN_AND:          ctrl_c = C_AND;
        FN_OR:           ctrl_c = C_OR;
        FN_XOR:          ctrl_c = C_XOR;
        FN_NOR:          ctrl_c = C_NOR;
        FN_SLT:          ctrl_c = C_SLT;
        FN_SLTU:         ctrl_c = C_SLTU;
        FN_SLL:          ctrl_c = C_SLL;
        FN_SRL:          ctrl_c = C_SRL;
        FN_SRA:          ctrl_c = C_SRA;
        FN_MFHI: begin
          ctrl_c = C_ADD; sel_c = 2'b01; md_class_c = 1'b1;
        end
        FN_MFLO: begin
          ctrl_c = C_ADD; sel_c = 2'b10; md_class_c = 1'b1;
        end
        FN_MTHI: begin
          ctrl_c = C_ADD; md_class_c = 1'b1; is_mthi_c = 1'b1;
        end
        FN_MTLO: begin
          ctrl_c = C_ADD; md_class_c = 1'b1; is_mtlo_c = 1'b1;
        end
        FN_MULT, FN_MULTU: begin
          ctrl_c = C_ADD; md_class_c = 1'b1; is_mul_c = 1'b1;
          is_signed_c = (bus.fn_field == FN_MULT);
        end
        FN_DIV, FN_DIVU: begin
          ctrl_c = C_ADD; md_class_c = 1'b1; is_div_c = 1'b1;
          is_signed_c = (bus.fn_field == FN_DIV);
        end
        default: illegal_c = 1'b1;
      endcase
    end
  end

  assign issue_c = bus.valid & !bus.flush & (is_mul_c | is_div_c);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (issue_c) state_d = is_mul_c ? S_MUL : S_DIV;
      S_MUL,
      S_DIV:  if (bus.flush || cnt_q == CNT_W'(1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_c  = (state_q != S_IDLE);
    step_c  = busy_c & !bus.flush;
    done_c  = step_c & (cnt_q == CNT_W'(1));
    mt_ok_c = bus.valid & !bus.flush & !busy_c;
  end

  // Operand magnitudes; unsigned ops pass raw operands through.
  logic          rs_neg_c, rt_neg_c;
  logic [N-1:0]  rs_mag_c, rt_mag_c;
  always_comb begin
    rs_neg_c = is_signed_c & bus.rs_val[N-1];
    rt_neg_c = is_signed_c & bus.rt_val[N-1];
    rs_mag_c = rs_neg_c ? -bus.rs_val : bus.rs_val;
    rt_mag_c = rt_neg_c ? -bus.rt_val : bus.rt_val;
  end

  // One radix-2 iteration: shift-add for MUL, restoring subtract for DIV.
  logic [N:0]       mul_sum_c, div_trial_c;
  logic [ACC_W-1:0] acc_step_c, prod_c;
  logic [N-1:0]     quo_c, rem_c, new_hi_c, new_lo_c;
  always_comb begin
    mul_sum_c   = {1'b0, acc_q[ACC_W-1:N]} + (acc_q[0] ? {1'b0, opb_q} : (N+1)'(0));
    div_trial_c = acc_q[ACC_W-1:N-1] - {1'b0, opb_q};
    if (state_q == S_MUL)
      acc_step_c = {mul_sum_c, acc_q[N-1:1]};
    else if (div_trial_c[N])
      acc_step_c = {acc_q[ACC_W-2:0], 1'b0};
    else
      acc_step_c = {div_trial_c[N-1:0], acc_q[N-2:0], 1'b1};

    prod_c = neg_res_q ? -acc_step_c : acc_step_c;
    quo_c  = acc_step_c[N-1:0];
    rem_c  = acc_step_c[ACC_W-1:N];
    if (state_q == S_MUL) begin
      new_hi_c = prod_c[ACC_W-1:N];
      new_lo_c = prod_c[N-1:0];
    end else begin
      new_hi_c = neg_rem_q ? -rem_c : rem_c;
      // Divide-by-zero: remainder already equals the latched dividend.
      new_lo_c = (opb_q == '0) ? '1 : (neg_res_q ? -quo_c : quo_c);
    end
  end

  // Engine datapath, counter and HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      if (issue_c && !busy_c) begin
        acc_q     <= {N'(0), is_mul_c ? rt_mag_c : rs_mag_c};
        opb_q     <= is_mul_c ? rs_mag_c : rt_mag_c;
        neg_res_q <= rs_neg_c ^ rt_neg_c;
        neg_rem_q <= rs_neg_c;
        cnt_q     <= CNT_W'(N);
      end else if (step_c) begin
        acc_q <= acc_step_c;
        cnt_q <= cnt_q - CNT_W'(1);
      end else if (busy_c) begin
        cnt_q <= '0;
      end

      if (done_c) begin
        hi_q <= new_hi_c;
        lo_q <= new_lo_c;
      end else if (mt_ok_c) begin
        if (is_mthi_c) hi_q <= bus.rs_val;
        if (is_mtlo_c) lo_q <= bus.rs_val;
      end
    end
  end

  assign bus.alu_ctrl   = ctrl_c;
  assign bus.result_sel = sel_c;
  assign bus.illegal    = illegal_c;
  assign bus.stall      = bus.valid & md_class_c & busy_c;
  assign bus.md_busy    = busy_c;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;

endmodule

// File: tb/tb_alu_control_md.sv
// Directed bench for alu_control_md: decode table sweep plus mul/div sequences.
module tb_alu_control_md;
  localparam int unsigned N = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_control_md_if #(.N(N), .N_FN_FIELD(6), .N_ALU_CTRL(4), .N_ALU_OP(2)) bus ();

  alu_control_md #(.N(N), .N_FN_FIELD(6), .N_ALU_CTRL(4), .N_ALU_OP(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] ctrl;
    logic [1:0] sel;
    logic       ill;
  } dec_vec_t;

  dec_vec_t vecs [24];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
    bus.valid    = v;
    bus.alu_op   = op;
    bus.fn_field = fn;
    bus.rs_val   = a;
    bus.rt_val   = b;
  endtask

  // Issue one mul/div, count busy cycles, then check HI/LO.
  task automatic run_md(input string name, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int busy_n;
    busy_n = 0;
    drive(1'b1, 2'b10, fn, a, b);
    tick();
    drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    for (int k = 0; k < 2 * N + 4; k++) begin
      if (!bus.md_busy) break;
      busy_n++;
      tick();
    end
    chk({name, " busy_cycles"}, 64'(busy_n), 64'(N));
    chk({name, " hi"}, 64'(bus.hi), 64'(eh));
    chk({name, " lo"}, 64'(bus.lo), 64'(el));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int stall_n, cyc_n;

    vecs[0]  = '{2'b10, 6'b100000, 4'b0010, 2'b00, 1'b0};
    vecs[1]  = '{2'b10, 6'b100001, 4'b0010, 2'b00, 1'b0};
    vecs[2]  = '{2'b10, 6'b100010, 4'b0110, 2'b00, 1'b0};
    vecs[3]  = '{2'b10, 6'b100011, 4'b0110, 2'b00, 1'b0};
    vecs[4]  = '{2'b10, 6'b100100, 4'b0000, 2'b00, 1'b0};
    vecs[5]  = '{2'b10, 6'b100101, 4'b0001, 2'b00, 1'b0};
    vecs[6]  = '{2'b10, 6'b100110, 4'b0011, 2'b00, 1'b0};
    vecs[7]  = '{2'b10, 6'b100111, 4'b1100, 2'b00, 1'b0};
    vecs[8]  = '{2'b10, 6'b101010, 4'b0111, 2'b00, 1'b0};
    vecs[9]  = '{2'b10, 6'b101011, 4'b1000, 2'b00, 1'b0};
    vecs[10] = '{2'b10, 6'b000000, 4'b1001, 2'b00, 1'b0};
    vecs[11] = '{2'b10, 6'b000010, 4'b1010, 2'b00, 1'b0};
    vecs[12] = '{2'b10, 6'b000011, 4'b1011, 2'b00, 1'b0};
    vecs[13] = '{2'b10, 6'b010000, 4'b0010, 2'b01, 1'b0};
    vecs[14] = '{2'b10, 6'b010010, 4'b0010, 2'b10, 1'b0};
    vecs[15] = '{2'b10, 6'b010001, 4'b0010, 2'b00, 1'b0};
    vecs[16] = '{2'b10, 6'b010011, 4'b0010, 2'b00, 1'b0};
    vecs[17] = '{2'b10, 6'b011000, 4'b0010, 2'b00, 1'b0};
    vecs[18] = '{2'b10, 6'b011001, 4'b0010, 2'b00, 1'b0};
    vecs[19] = '{2'b10, 6'b011010, 4'b0010, 2'b00, 1'b0};
    vecs[20] = '{2'b10, 6'b011011, 4'b0010, 2'b00, 1'b0};
    vecs[21] = '{2'b00, 6'b111111, 4'b0010, 2'b00, 1'b0};
    vecs[22] = '{2'b01, 6'b101010, 4'b0110, 2'b00, 1'b0};
    vecs[23] = '{2'b10, 6'b111111, 4'b1111, 2'b00, 1'b1};

    rst = 1'b1;
    bus.flush = 1'b0;
    drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    chk("reset hi", 64'(bus.hi), 64'd0);
    chk("reset lo", 64'(bus.lo), 64'd0);
    chk("reset md_busy", 64'(bus.md_busy), 64'd0);
    chk("reset stall", 64'(bus.stall), 64'd0);

    // Decode sweep with valid low so nothing issues.
    for (int i = 0; i < 24; i++) begin
      drive(1'b0, vecs[i].op, vecs[i].fn, 32'd0, 32'd0);
      #1;
      chk($sformatf("dec[%0d] alu_ctrl", i), 64'(bus.alu_ctrl), 64'(vecs[i].ctrl));
      chk($sformatf("dec[%0d] result_sel", i), 64'(bus.result_sel), 64'(vecs[i].sel));
      chk($sformatf("dec[%0d] illegal", i), 64'(bus.illegal), 64'(vecs[i].ill));
    end
    drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    tick();

    run_md("multu ff*ff", 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_md("mult -3*5",   6'b011000, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_md("div -7/2",    6'b011010, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu 9/0",    6'b011011, 32'd9,         32'd0,         32'd9,         32'hFFFF_FFFF);
    run_md("div min/-1",  6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
    run_md("divu 100/7",  6'b011011, 32'd100,       32'd7,         32'd2,         32'd14);

    // mflo held from T+1 stalls until the engine finishes; an add mid-way does not.
    drive(1'b1, 2'b10, 6'b011001, 32'd7, 32'd6);
    tick();
    stall_n = 0;
    cyc_n   = 0;
    for (int k = 0; k < 2 * N + 4; k++) begin
      if (!bus.md_busy) break;
      if (k == 2) begin
        drive(1'b1, 2'b10, 6'b100000, 32'd1, 32'd1);
        #1;
        chk("add during busy stall", 64'(bus.stall), 64'd0);
      end else begin
        drive(1'b1, 2'b10, 6'b010010, 32'd0, 32'd0);
        #1;
        if (bus.stall) stall_n++;
      end
      cyc_n++;
      tick();
    end
    drive(1'b1, 2'b10, 6'b010010, 32'd0, 32'd0);
    #1;
    chk("mflo busy cycles", 64'(cyc_n), 64'(N));
    chk("mflo stalled cycles", 64'(stall_n), 64'(N - 1));
    chk("mflo release stall", 64'(bus.stall), 64'd0);
    chk("mflo result_sel", 64'(bus.result_sel), 64'd2);
    chk("mflo new lo", 64'(bus.lo), 64'd42);
    chk("mflo new hi", 64'(bus.hi), 64'd0);
    tick();

    // mtlo / mthi write only the targeted register.
    drive(1'b1, 2'b10, 6'b010011, 32'h55, 32'd0);
    tick();
    chk("mtlo lo", 64'(bus.lo), 64'h55);
    chk("mtlo hi kept", 64'(bus.hi), 64'd0);
    drive(1'b1, 2'b10, 6'b010001, 32'h1234, 32'd0);
    tick();
    chk("mthi hi", 64'(bus.hi), 64'h1234);
    chk("mthi lo kept", 64'(bus.lo), 64'h55);

    // flush in IDLE blocks mthi and mult issue.
    bus.flush = 1'b1;
    drive(1'b1, 2'b10, 6'b010001, 32'hDEAD, 32'd0);
    tick();
    chk("flushed mthi hi", 64'(bus.hi), 64'h1234);
    drive(1'b1, 2'b10, 6'b011000, 32'd2, 32'd3);
    tick();
    chk("flushed mult busy", 64'(bus.md_busy), 64'd0);
    bus.flush = 1'b0;

    // mult 2*3 aborted by flush at T+5.
    drive(1'b1, 2'b10, 6'b011000, 32'd2, 32'd3);
    tick();
    drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    for (int k = 0; k < 4; k++) tick();
    chk("pre-flush busy", 64'(bus.md_busy), 64'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("post-flush busy", 64'(bus.md_busy), 64'd0);
    chk("post-flush hi", 64'(bus.hi), 64'h1234);
    chk("post-flush lo", 64'(bus.lo), 64'h55);
    tick();
    chk("flush no late write lo", 64'(bus.lo), 64'h55);

    // Reset at T+10 of a div clears everything.
    drive(1'b1, 2'b10, 6'b011010, 32'd100, 32'd7);
    tick();
    drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    for (int k = 0; k < 9; k++) tick();
    chk("pre-rst busy", 64'(bus.md_busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst mid-div hi", 64'(bus.hi), 64'd0);
    chk("rst mid-div lo", 64'(bus.lo), 64'd0);
    chk("rst mid-div busy", 64'(bus.md_busy), 64'd0);
    for (int k = 0; k < N + 2; k++) tick();
    chk("rst no late write lo", 64'(bus.lo), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
